// File: rtl/eth_rx_payload_filter.sv
// Ethernet RX payload filter: MAC/EtherType match, header strip,
// commit-on-good-frame payload FIFO with FWFT valid/ready output.
module eth_rx_payload_filter #(
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned FIFO_DEPTH = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  input  logic        i_err,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  input  logic        i_ready,
  output logic [15:0] o_frames_ok,
  output logic [15:0] o_frames_drop
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_PAY  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    hcnt_q, hcnt_d;
  logic          ucast_q, ucast_d;
  logic          bcast_q, bcast_d;
  logic          type_q, type_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cm_q, cm_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [15:0]   ok_q, ok_d;
  logic [15:0]   drop_q, drop_d;
  logic          rv_q, rv_d;
  logic          ov_q, ov_d;
  logic [8:0]    out_q, out_d;
  logic [8:0]    ram_q;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [7:0]    mac_b, type_b;
  logic          full, we, re, move;

  always_comb begin
    mac_b = LOCAL_MAC[7:0];
    case (hcnt_q)
      4'd0:    mac_b = LOCAL_MAC[47:40];
      4'd1:    mac_b = LOCAL_MAC[39:32];
      4'd2:    mac_b = LOCAL_MAC[31:24];
      4'd3:    mac_b = LOCAL_MAC[23:16];
      4'd4:    mac_b = LOCAL_MAC[15:8];
      default: mac_b = LOCAL_MAC[7:0];
    endcase
  end

  assign type_b = hcnt_q[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
  assign full   = (wr_q - rd_q) == PW'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    ucast_d = ucast_q;
    bcast_d = bcast_q;
    type_d  = type_q;
    ovf_d   = ovf_q;
    wr_d    = wr_q;
    cm_d    = cm_q;
    ok_d    = ok_q;
    drop_d  = drop_q;
    we      = 1'b0;
    if (i_valid) begin
      unique case (1'b1)
        state_q == S_PAY: begin
          we    = !full;
          ovf_d = ovf_q | full;
          wr_d  = wr_q + PW'(we);
          if (i_last) begin
            if (i_err || ovf_d) begin
              wr_d   = cm_q;
              drop_d = drop_q + 16'd1;
            end else begin
              cm_d = wr_d;
              ok_d = ok_q + 16'd1;
            end
            state_d = S_HDR;
          end
        end
        state_q == S_DROP: begin
          if (i_last) begin
            drop_d  = drop_q + 16'd1;
            state_d = S_HDR;
          end
        end
        default: begin
          if (hcnt_q < 4'd6) begin
            ucast_d = ucast_q | (i_data != mac_b);
            bcast_d = bcast_q | (i_data != 8'hFF);
          end
          if (hcnt_q >= 4'd12) type_d = type_q | (i_data != type_b);
          hcnt_d = hcnt_q + 4'd1;
          if (i_last) begin
            drop_d  = drop_q + 16'd1;
            state_d = S_HDR;
          end else if (hcnt_q == 4'd13) begin
            state_d = ((!ucast_d || !bcast_d) && !type_d) ? S_PAY : S_DROP;
          end
        end
      endcase
      if (i_last) begin
        hcnt_d  = 4'd0;
        ucast_d = 1'b0;
        bcast_d = 1'b0;
        type_d  = 1'b0;
        ovf_d   = 1'b0;
      end
    end
  end

  // rv_q tracks the RAM output register; it is only refilled when its
  // current word is moving into the output register, so stalls lose nothing.
  always_comb begin
    move  = !ov_q || i_ready;
    re    = (cm_q != rd_q) && (!rv_q || move);
    rd_d  = rd_q + PW'(re);
    rv_d  = re | (rv_q & !move);
    ov_d  = move ? rv_q : ov_q;
    out_d = (move && rv_q) ? ram_q : out_q;
  end

  always_ff @(posedge i_clk) begin
    if (we) mem[wr_q[AW-1:0]] <= {i_last, i_data};
    if (re) ram_q <= mem[rd_q[AW-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_HDR;
      hcnt_q  <= 4'd0;
      ucast_q <= 1'b0;
      bcast_q <= 1'b0;
      type_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      ok_q    <= 16'd0;
      drop_q  <= 16'd0;
      rv_q    <= 1'b0;
      ov_q    <= 1'b0;
      out_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      ucast_q <= ucast_d;
      bcast_q <= bcast_d;
      type_q  <= type_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      rd_q    <= rd_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
      rv_q    <= rv_d;
      ov_q    <= ov_d;
      out_q   <= out_d;
    end
  end

  assign o_valid       = ov_q;
  assign o_data        = out_q[7:0];
  assign o_last        = out_q[8];
  assign o_frames_ok   = ok_q;
  assign o_frames_drop = drop_q;
endmodule

// File: tb/tb_eth_rx_payload_filter.sv
// Scoreboard bench for eth_rx_payload_filter: frame-level reference
// model feeds an expected-byte queue drained by an output monitor.
module tb_eth_rx_payload_filter;
  localparam int DEPTH = 64;
  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ET  = 16'h88B5;

  logic        clk = 0;
  logic        rst_n;
  logic        i_valid, i_last, i_err, i_ready;
  logic [7:0]  i_data;
  logic        o_valid, o_last;
  logic [7:0]  o_data;
  logic [15:0] o_ok, o_drop;

  eth_rx_payload_filter #(.LOCAL_MAC(MAC), .ETHERTYPE(ET), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .i_err(i_err),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(i_ready),
    .o_frames_ok(o_ok), .o_frames_drop(o_drop)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];
  logic [7:0] fb[$];
  logic [15:0] m_ok = 0, m_drop = 0;
  bit rdy_rand = 0;
  bit rdy_fix = 1;
  bit stall_q = 0;
  logic [8:0] held;

  always @(posedge clk) begin
    #1;
    i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  always @(negedge clk) begin
    if (!rst_n) stall_q = 0;
    else begin
      if (stall_q) begin
        checks++;
        if (!o_valid || {o_last, o_data} != held) begin
          errors++;
          $display("FAIL hold: got v=%0b %h want v=1 %h", o_valid, {o_last, o_data}, held);
        end
      end
      if (o_valid && i_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %h want none", {o_last, o_data});
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          if (e != {o_last, o_data}) begin
            errors++;
            $display("FAIL payload: got %h want %h", {o_last, o_data}, e);
          end
        end
      end
      stall_q = o_valid && !i_ready;
      held = {o_last, o_data};
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] typ,
                       input int total, input bit seq);
    fb.delete();
    for (int i = 0; i < total; i++) begin
      if (i < 6) fb.push_back(dst[8*(5-i) +: 8]);
      else if (i < 12) fb.push_back(8'($urandom));
      else if (i == 12) fb.push_back(typ[15:8]);
      else if (i == 13) fb.push_back(typ[7:0]);
      else fb.push_back(seq ? 8'(i - 14) : 8'($urandom));
    end
  endtask

  // Frame-level model: accepted iff long enough, address and type match,
  // no error and the payload fits in the space not held by pending bytes.
  task automatic send(input bit err, input int ncut);
    logic [47:0] dst;
    logic [15:0] typ;
    int plen;
    bit acc;
    if (ncut == fb.size()) begin
      dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
      typ = {fb[12], fb[13]};
      plen = fb.size() - 14;
      acc = plen > 0 && (dst == MAC || dst == BC) && typ == ET && !err
            && (sb.size() + plen <= DEPTH);
      if (acc) begin
        for (int i = 14; i < fb.size(); i++)
          sb.push_back({i == fb.size() - 1, fb[i]});
        m_ok++;
      end else m_drop++;
    end
    for (int i = 0; i < ncut; i++) begin
      i_valid = 1;
      i_data  = fb[i];
      i_last  = (i == fb.size() - 1);
      i_err   = i_last & err;
      @(posedge clk); #1;
    end
    i_valid = 0; i_last = 0; i_err = 0;
    if (ncut == fb.size()) begin
      chk("frames_ok", 32'(o_ok), 32'(m_ok));
      chk("frames_drop", 32'(o_drop), 32'(m_drop));
    end
  endtask

  task automatic wait_room(input int need);
    int n = 0;
    while (sb.size() + need > DEPTH && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) chk("room_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || o_valid) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", 32'(sb.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 0; i_valid = 0; i_data = 0; i_last = 0; i_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'({o_last, o_data}), 0);
    chk("rst_ok", 32'(o_ok), 0);
    chk("rst_drop", 32'(o_drop), 0);
    rst_n = 1;
    @(posedge clk); #1;

    build(MAC, ET, 60, 1);
    send(0, 60);
    cyc = 0;
    while (!o_valid && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", 32'(cyc), 2);
    drain();

    build(BC, ET, 40, 0);                 send(0, 40);
    build(48'h02_00_00_00_00_02, ET, 40, 0); send(0, 40);
    build(MAC, 16'h0800, 40, 0);          send(0, 40);
    build(MAC, ET, 50, 0);                send(1, 50);
    build(MAC, ET, 30, 0);                send(0, 30);
    build(MAC, ET, 10, 0);                send(0, 10);
    build(MAC, ET, 14, 0);                send(0, 14);
    build(MAC, ET, 15, 0);                send(0, 15);
    drain();

    rdy_fix = 0;
    build(MAC, ET, 114, 0); send(0, 114);
    repeat (10) @(posedge clk);
    #1 chk("ovf_empty", 32'(o_valid), 0);
    build(MAC, ET, 34, 0); send(0, 34);
    repeat (10) @(posedge clk);
    #1 rdy_fix = 1;
    drain();
    rdy_fix = 0;
    build(MAC, ET, 14 + DEPTH, 0); send(0, 14 + DEPTH);
    rdy_fix = 1;
    drain();
    rdy_fix = 0;
    build(MAC, ET, 15 + DEPTH, 0); send(0, 15 + DEPTH);
    repeat (5) @(posedge clk);
    #1 chk("ovf65_empty", 32'(o_valid), 0);
    rdy_fix = 1;

    rdy_rand = 1;
    for (int f = 0; f < 3; f++) begin
      build(MAC, ET, 20 + f * 7, 0); send(0, 20 + f * 7);
    end
    for (int f = 0; f < 40; f++) begin
      logic [47:0] d;
      int len;
      case ($urandom_range(0, 3))
        0: d = BC;
        1: d = MAC ^ (48'h1 << (8 * $urandom_range(0, 5)));
        default: d = MAC;
      endcase
      len = $urandom_range(8, 50);
      build(d, ($urandom_range(0, 5) == 0) ? 16'h0800 : ET, len, 0);
      wait_room(len);
      send($urandom_range(0, 7) == 0, len);
    end
    rdy_rand = 0;
    rdy_fix = 1;
    drain();

    rdy_fix = 0;
    build(MAC, ET, 34, 0); send(0, 34);
    build(MAC, ET, 60, 0); send(0, 30);
    rst_n = 0;
    #1;
    chk("mrst_valid", 32'(o_valid), 0);
    chk("mrst_data", 32'({o_last, o_data}), 0);
    chk("mrst_ok", 32'(o_ok), 0);
    chk("mrst_drop", 32'(o_drop), 0);
    sb.delete();
    m_ok = 0; m_drop = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rdy_fix = 1;
    @(posedge clk); #1;
    build(MAC, ET, 40, 1); send(0, 40);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
